// File: rtl/text_video_timing.sv
// Raster timing generator for the text-mode colour mapper: scan counters plus a pipelined hsync/vsync/vde.
// Define TEXT_VIDEO_TIMING_FRAME_CNT_EN to enable frame_start / frame_count; otherwise they are tied to 0.
module text_video_timing #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit SYNC_POL   = 1'b0,
  parameter int PIPE_DEPTH = 2
) (
  input  logic       pixel_clk,
  input  logic       reset,
  output logic [9:0] drawX,
  output logic [9:0] drawY,
  output logic       hsync,
  output logic       vsync,
  output logic       vde,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam logic [9:0] H_MAX    = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_MAX    = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       hs_lvl;
  logic       vs_lvl;
  logic       de_raw;

  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      hc <= '0;
      vc <= '0;
    end else if (hc == H_MAX) begin
      hc <= '0;
      vc <= (vc == V_MAX) ? 10'd0 : vc + 10'd1;
    end else begin
      hc <= hc + 10'd1;
    end
  end

  assign drawX  = hc;
  assign drawY  = vc;
  assign hs_lvl = ((hc >= HS_FIRST) && (hc <= HS_LAST)) ? SYNC_POL : ~SYNC_POL;
  assign vs_lvl = ((vc >= VS_FIRST) && (vc <= VS_LAST)) ? SYNC_POL : ~SYNC_POL;
  assign de_raw = (hc < H_VIS) && (vc < V_VIS);

  generate
    if (PIPE_DEPTH == 0) begin : g_passthru
      // With no pipeline registers, reset has to mask the raw timing directly.
      assign hsync = reset ? ~SYNC_POL : hs_lvl;
      assign vsync = reset ? ~SYNC_POL : vs_lvl;
      assign vde   = reset ? 1'b0 : de_raw;
    end else begin : g_pipe
      logic [PIPE_DEPTH-1:0] hs_sr;
      logic [PIPE_DEPTH-1:0] vs_sr;
      logic [PIPE_DEPTH-1:0] de_sr;

      always_ff @(posedge pixel_clk) begin
        if (reset) begin
          hs_sr <= {PIPE_DEPTH{~SYNC_POL}};
          vs_sr <= {PIPE_DEPTH{~SYNC_POL}};
          de_sr <= '0;
        end else begin
          hs_sr[0] <= hs_lvl;
          vs_sr[0] <= vs_lvl;
          de_sr[0] <= de_raw;
          for (int i = 1; i < PIPE_DEPTH; i++) begin
            hs_sr[i] <= hs_sr[i-1];
            vs_sr[i] <= vs_sr[i-1];
            de_sr[i] <= de_sr[i-1];
          end
        end
      end

      assign hsync = hs_sr[PIPE_DEPTH-1];
      assign vsync = vs_sr[PIPE_DEPTH-1];
      assign vde   = de_sr[PIPE_DEPTH-1];
    end
  endgenerate

`ifdef TEXT_VIDEO_TIMING_FRAME_CNT_EN
  logic [7:0] frame_cnt_q;

  // Counts on the same edge that wraps vc back to line 0.
  always_ff @(posedge pixel_clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else if ((hc == H_MAX) && (vc == V_MAX)) begin
      frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign frame_start = (hc == 10'd0) && (vc == 10'd0) && !reset;
  assign frame_count = frame_cnt_q;
`else
  assign frame_start = 1'b0;
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_text_video_timing.sv
// Bench for text_video_timing: a full-size 800x525 instance (PIPE_DEPTH 2, active-low sync)
// and a tiny 16x11 instance (PIPE_DEPTH 0, active-high sync) so whole frames fit in a short run.
module tb_text_video_timing;

  logic       pixel_clk = 1'b0;
  logic       reset_a = 1'b1;
  logic       reset_b = 1'b1;
  logic [9:0] drawX_a, drawY_a, drawX_b, drawY_b;
  logic       hsync_a, vsync_a, vde_a, frame_start_a;
  logic       hsync_b, vsync_b, vde_b, frame_start_b;
  logic [7:0] frame_count_a, frame_count_b;

  int checks = 0;
  int errors = 0;
  int t_a = 0;
  int t_b = 0;
  bit valid_a = 1'b0;
  bit valid_b = 1'b0;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [7:0] fc;
  } exp_t;

  always #5 pixel_clk = ~pixel_clk;

  text_video_timing dut_a (
    .pixel_clk(pixel_clk), .reset(reset_a), .drawX(drawX_a), .drawY(drawY_a),
    .hsync(hsync_a), .vsync(vsync_a), .vde(vde_a),
    .frame_start(frame_start_a), .frame_count(frame_count_a)
  );

  text_video_timing #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b1), .PIPE_DEPTH(0)
  ) dut_b (
    .pixel_clk(pixel_clk), .reset(reset_b), .drawX(drawX_b), .drawY(drawY_b),
    .hsync(hsync_b), .vsync(vsync_b), .vde(vde_b),
    .frame_start(frame_start_b), .frame_count(frame_count_b)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input int which, input logic value);
    if (which == 0) reset_a = value;
    else reset_b = value;
  endtask

  // t = number of running edges since the last reset edge; outputs follow from raster arithmetic on t.
  function automatic exp_t model_out(input int t, input int ha, input int hfp, input int hsw, input int hbp,
                                     input int va, input int vfp, input int vsw, input int vbp,
                                     input bit pol, input int pd, input bit rst);
    exp_t e;
    int ht, vt, td, dx, dy;
    ht = ha + hfp + hsw + hbp;
    vt = va + vfp + vsw + vbp;
    e.x = 10'(t % ht);
    e.y = 10'((t / ht) % vt);
    td = t - pd;
    if (td < 0 || (pd == 0 && rst)) begin
      e.hs = ~pol;
      e.vs = ~pol;
      e.de = 1'b0;
    end else begin
      dx = td % ht;
      dy = (td / ht) % vt;
      e.hs = (dx >= ha + hfp && dx < ha + hfp + hsw) ? pol : ~pol;
      e.vs = (dy >= va + vfp && dy < va + vfp + vsw) ? pol : ~pol;
      e.de = (dx < ha) && (dy < va);
    end
`ifdef TEXT_VIDEO_TIMING_FRAME_CNT_EN
    e.fs = ((t % (ht * vt)) == 0) && !rst;
    e.fc = 8'((t / (ht * vt)) % 256);
`else
    e.fs = 1'b0;
    e.fc = 8'd0;
`endif
    return e;
  endfunction

  always @(posedge pixel_clk) begin
    if (reset_a) begin t_a = 0; valid_a = 1'b1; end
    else if (valid_a) t_a++;
    if (reset_b) begin t_b = 0; valid_b = 1'b1; end
    else if (valid_b) t_b++;
  end

  always @(negedge pixel_clk) begin : compare
    exp_t ea;
    exp_t eb;
    if (valid_a) begin
      ea = model_out(t_a, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 2, reset_a);
      checkOutput("a_drawX", drawX_a, ea.x);
      checkOutput("a_drawY", drawY_a, ea.y);
      checkOutput("a_hsync", hsync_a, ea.hs);
      checkOutput("a_vsync", vsync_a, ea.vs);
      checkOutput("a_vde", vde_a, ea.de);
      checkOutput("a_frame_start", frame_start_a, ea.fs);
      checkOutput("a_frame_count", frame_count_a, ea.fc);
    end
    if (valid_b) begin
      eb = model_out(t_b, 8, 2, 3, 3, 6, 1, 2, 2, 1'b1, 0, reset_b);
      checkOutput("b_drawX", drawX_b, eb.x);
      checkOutput("b_drawY", drawY_b, eb.y);
      checkOutput("b_hsync", hsync_b, eb.hs);
      checkOutput("b_vsync", vsync_b, eb.vs);
      checkOutput("b_vde", vde_b, eb.de);
      checkOutput("b_frame_start", frame_start_b, eb.fs);
      checkOutput("b_frame_count", frame_count_b, eb.fc);
    end
  end

  initial begin
    fork
      begin : stim_a
        int hs_low, de_high, first_x, last_x;
        hs_low = 0; de_high = 0; first_x = -1; last_x = -1;
        repeat (4) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checkOutput("a_rst_drawX", drawX_a, 0);
        checkOutput("a_rst_drawY", drawY_a, 0);
        checkOutput("a_rst_hsync", hsync_a, 1);
        checkOutput("a_rst_vsync", vsync_a, 1);
        checkOutput("a_rst_vde", vde_a, 0);
        @(posedge pixel_clk); #1 applyStimulus(0, 1'b0);
        @(posedge pixel_clk); @(negedge pixel_clk);
        checkOutput("a_release_drawX", drawX_a, 1);
        checkOutput("a_release_vde", vde_a, 0);
        @(posedge pixel_clk); @(negedge pixel_clk);
        checkOutput("a_first_vde", vde_a, 1);
        for (int t = 3; t <= 802; t++) begin
          @(posedge pixel_clk); @(negedge pixel_clk);
          if (hsync_a == 1'b0) begin
            hs_low++;
            if (first_x < 0) first_x = int'(drawX_a);
            last_x = int'(drawX_a);
          end
          if (vde_a == 1'b1) de_high++;
          if (t == 799) begin
            checkOutput("a_line_end_x", drawX_a, 799);
            checkOutput("a_line_end_y", drawY_a, 0);
          end
          if (t == 800) begin
            checkOutput("a_line_wrap_x", drawX_a, 0);
            checkOutput("a_line_wrap_y", drawY_a, 1);
          end
        end
        checkOutput("a_hsync_low_count", hs_low, 96);
        checkOutput("a_hsync_first_x", first_x, 658);
        checkOutput("a_hsync_last_x", last_x, 753);
        checkOutput("a_vde_line_count", de_high, 640);
        repeat (698) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checkOutput("a_mid_drawX", drawX_a, 700);
        checkOutput("a_mid_hsync", hsync_a, 0);
        #1 applyStimulus(0, 1'b1);
        @(posedge pixel_clk); @(negedge pixel_clk);
        checkOutput("a_midrst_drawX", drawX_a, 0);
        checkOutput("a_midrst_drawY", drawY_a, 0);
        checkOutput("a_midrst_hsync", hsync_a, 1);
        checkOutput("a_midrst_vde", vde_a, 0);
        @(posedge pixel_clk); #1 applyStimulus(0, 1'b0);
        repeat (10) @(posedge pixel_clk);
      end
      begin : stim_b
        int vs_high, hs_high, de_high;
        vs_high = 0; hs_high = 0; de_high = 0;
        repeat (4) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checkOutput("b_rst_drawX", drawX_b, 0);
        checkOutput("b_rst_hsync", hsync_b, 0);
        checkOutput("b_rst_vsync", vsync_b, 0);
        checkOutput("b_rst_vde", vde_b, 0);
        @(posedge pixel_clk); #1 applyStimulus(1, 1'b0);
        @(negedge pixel_clk);
        checkOutput("b_pd0_vde_at_origin", vde_b, 1);
        for (int t = 1; t <= 176; t++) begin
          @(posedge pixel_clk); @(negedge pixel_clk);
          if (vsync_b == 1'b1) vs_high++;
          if (hsync_b == 1'b1) hs_high++;
          if (vde_b == 1'b1) de_high++;
          if (t == 8) checkOutput("b_vde_off_x8", vde_b, 0);
          if (t == 10) checkOutput("b_hsync_on_x10", hsync_b, 1);
          if (t == 175) begin
            checkOutput("b_corner_x", drawX_b, 15);
            checkOutput("b_corner_y", drawY_b, 10);
          end
          if (t == 176) begin
            checkOutput("b_wrap_x", drawX_b, 0);
            checkOutput("b_wrap_y", drawY_b, 0);
            checkOutput("b_wrap_vde", vde_b, 1);
`ifdef TEXT_VIDEO_TIMING_FRAME_CNT_EN
            checkOutput("b_wrap_frame_start", frame_start_b, 1);
            checkOutput("b_wrap_frame_count", frame_count_b, 1);
`else
            checkOutput("b_wrap_frame_start", frame_start_b, 0);
            checkOutput("b_wrap_frame_count", frame_count_b, 0);
`endif
          end
        end
        checkOutput("b_vsync_frame_count", vs_high, 32);
        checkOutput("b_hsync_frame_count", hs_high, 33);
        checkOutput("b_vde_frame_count", de_high, 48);
        repeat (139) @(posedge pixel_clk);
        @(negedge pixel_clk);
        checkOutput("b_mid_hsync", hsync_b, 1);
        checkOutput("b_mid_vsync", vsync_b, 1);
        #1 applyStimulus(1, 1'b1);
        @(posedge pixel_clk); @(negedge pixel_clk);
        checkOutput("b_midrst_drawX", drawX_b, 0);
        checkOutput("b_midrst_drawY", drawY_b, 0);
        checkOutput("b_midrst_hsync", hsync_b, 0);
        checkOutput("b_midrst_vsync", vsync_b, 0);
        checkOutput("b_midrst_frame_count", frame_count_b, 0);
        @(posedge pixel_clk); #1 applyStimulus(1, 1'b0);
        repeat (20) @(posedge pixel_clk);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_video_timing.md
Name: text_video_timing

Overview:
- Raster timing generator that sits directly upstream of the text-mode colour mapper.
- Produces the DrawX/DrawY scan coordinates that drive the colour mapper's VRAM/font addressing.
- Produces hsync, vsync and vde delayed by a programmable pipeline depth, so they line up with RGB leaving the BRAM + font-ROM path.
- Output feeds the HDMI/TMDS encoder.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- PIPE_DEPTH, 2, cycles of delay on hsync/vsync/vde (legal range 0..7)

Ports:
- pixel_clk  in  1  pixel clock; all state on rising edge
- reset  in  1  synchronous, active-high reset
- drawX  out  10  current horizontal count, undelayed
- drawY  out  10  current vertical count, undelayed
- hsync  out  1  horizontal sync, delayed PIPE_DEPTH
- vsync  out  1  vertical sync, delayed PIPE_DEPTH
- vde  out  1  video data enable (active region), delayed PIPE_DEPTH
- frame_start  out  1  one-cycle pulse (optional feature)
- frame_count  out  8  frame counter (optional feature)

Behaviour:
- Derived totals: H_TOTAL = sum of H params (800); V_TOTAL = sum of V params (525).
- hc, vc: 10-bit registers; drawX = hc, drawY = vc, both driven straight from the registers.
- Each cycle: hc increments. At hc = H_TOTAL-1, hc wraps to 0 and vc increments.
- At hc = H_TOTAL-1 and vc = V_TOTAL-1, both wrap to 0.
- Counters are never compared with wider arithmetic; all totals must fit in 10 bits.
- Raw combinational signals from hc/vc:
  - hs_raw asserted for H_ACTIVE+H_FP <= hc <= H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vs_raw asserted for V_ACTIVE+V_FP <= vc <= V_ACTIVE+V_FP+V_SYNC-1 (490..491).
  - de_raw = (hc < H_ACTIVE) and (vc < V_ACTIVE).
- Asserted level is SYNC_POL; deasserted level is its complement.
- Pipeline: hs/vs/de_raw each pass through a PIPE_DEPTH-stage shift register. Output at cycle t equals the raw value at t-PIPE_DEPTH.
- PIPE_DEPTH = 0 is a combinational pass-through.
- Reset (while reset = 1 at a clock edge):
  - hc = 0, vc = 0; every pipeline stage loads the deasserted sync level and de = 0.
  - Resulting outputs: drawX = 0, drawY = 0, hsync = vsync = ~SYNC_POL, vde = 0, frame_start = 0, frame_count = 0.
- After reset release: the first edge with reset = 0 advances hc to 1. vde first asserts PIPE_DEPTH cycles after the edge on which hc = 0 was presented.
- Reset mid-frame: counters and pipeline clear on that edge. No partial sync pulse persists beyond the reset edge.
- No enable input: the counters run every cycle.

Optional Feature:
- Macro: TEXT_VIDEO_TIMING_FRAME_CNT_EN
- Defined:
  - frame_start pulses high for exactly one cycle, on the cycle where hc = 0 and vc = 0, undelayed and aligned with drawX/drawY.
  - frame_count increments (mod 256) on the same edge that wraps vc to 0. Reset clears it.
  - Consumers (e.g. cursor blink) use frame_count[5].
- Undefined: frame_start and frame_count are tied to 0. The ports remain so the interface is stable.

Test Plan:
- Reset held 5 cycles, then released -> drawX = 0, drawY = 0, hsync = vsync = 1, vde = 0 during reset. drawX = 1 one cycle after release. vde = 1 first observed at release edge + 2 (PIPE_DEPTH = 2).
- Free-run one line -> drawX counts 0..799 and wraps to 0 while drawY goes 0 -> 1. hsync low exactly for drawX = 658..753 as sampled at the output (2-cycle lag), 96 cycles total.
- Free-run one full frame -> vsync low for exactly 2 lines (1600 cycles), starting when the delayed vc = 490. vde high for 640 x 480 = 307200 cycles per frame. Frame period = 420000 cycles.
- Wrap corner: at hc = 799, vc = 524 -> next cycle drawX = 0, drawY = 0. With the feature on: frame_start = 1 that cycle and frame_count 0 -> 1.
- Reset asserted at hc = 700, vc = 491 (inside hsync and vsync) -> on the next edge, hsync = vsync = 1, vde = 0, drawX = drawY = 0, frame_count = 0.
- PIPE_DEPTH = 0 build -> vde = 1 on the same cycle as drawX = 0, drawY = 0. vde = 0 at drawX = 640.
